// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator operator console.
//   - unit codes selected in MODE
//   - prompt text indices sent to the UART text block
//   - sequencer state encoding
//   - helper to compute the number of switch-bank words per operand
package calc_pkg;

    // Execution unit codes (110/111 are invalid)
    localparam logic [2:0] U_FPU   = 3'b000;
    localparam logic [2:0] U_ARITH = 3'b001;
    localparam logic [2:0] U_BIT   = 3'b010;
    localparam logic [2:0] U_LOGIC = 3'b011;
    localparam logic [2:0] U_FETCH = 3'b100;
    localparam logic [2:0] U_STORE = 3'b101;

    // Logic-unit operation that takes a single operand
    localparam logic [2:0] OP_NOT  = 3'b110;

    // Prompt text indices; unit menus are unit code + 1
    localparam logic [4:0] P_MODE    = 5'd0;
    localparam logic [4:0] P_ENTER_A = 5'd8;
    localparam logic [4:0] P_ENTER_B = 5'd9;
    localparam logic [4:0] P_OUTPUT  = 5'd10;
    localparam logic [4:0] P_ERROR   = 5'd11;

    typedef enum logic [2:0] {
        S_MODE = 3'd0,
        S_OP   = 3'd1,
        S_A    = 3'd2,
        S_B    = 3'd3,
        S_EXEC = 3'd4,
        S_WAIT = 3'd5,
        S_SHOW = 3'd6
    } state_t;

    function automatic int calc_words(input int data_w, input int sw_w);
        return data_w / sw_w;
    endfunction

endpackage

// File: rtl/calc_regfile.sv
// calc_regfile: NREGS x DATA_W store/fetch register file.
//   clk, rst : clock, asynchronous active-high clear of every register
//   we       : write enable, writes wdata to regs[waddr]
//   raddr    : combinational read address, rdata = regs[raddr]
module calc_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(NREGS)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata = regs_q[raddr];

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: operator-console sequencer for the FPGA calculator.
//   btn_pulse/switches        : debounced press and operator data
//   prompt_valid/id/arg/ready : prompt request to the UART text block
//   unit_sel/op_sel/opa/opb   : latched selection and assembled operands
//   start/result_valid/result : execution-unit launch and result capture
//   out/busy/err              : displayed value, EXEC/WAIT flag, sticky error
// The current FSM state is held in state_q for observation.
//
// Prompt handshake: prompt_valid rises when a prompting state is entered and
// holds with a stable id/arg until a cycle with prompt_valid && prompt_ready.
// A press is accepted only in a cycle with no prompt pending, so a press
// coincident with the handshake cycle is dropped.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SW_W    = 16,
    parameter int NREGS   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_pulse,
    input  logic [SW_W-1:0]   switches,
    output logic              prompt_valid,
    output logic [4:0]        prompt_id,
    output logic [7:0]        prompt_arg,
    input  logic              prompt_ready,
    output logic [2:0]        unit_sel,
    output logic [2:0]        op_sel,
    output logic [DATA_W-1:0] opa,
    output logic [DATA_W-1:0] opb,
    output logic              start,
    input  logic              result_valid,
    input  logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] out,
    output logic              busy,
    output logic              err
);

    localparam int WORDS = calc_words(DATA_W, SW_W);
    localparam int IDX_W = $clog2(NREGS);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t            state_q, state_d;
    logic              boot_q, boot_d;
    logic              prompt_valid_q, prompt_valid_d;
    logic [4:0]        prompt_id_q, prompt_id_d;
    logic [7:0]        prompt_arg_q, prompt_arg_d;
    logic [2:0]        unit_sel_q, unit_sel_d;
    logic [2:0]        op_sel_q, op_sel_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              err_q, err_d;
    logic [7:0]        k_q, k_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic              press;
    logic              single_operand;
    logic              rf_we;
    logic [DATA_W-1:0] rf_rdata;

    // boot_q keeps presses out of the first cycle after reset, when the
    // MODE prompt has not been raised yet.
    assign press = btn_pulse && !prompt_valid_q && !boot_q;

    assign single_operand = (unit_sel_q == U_STORE) ||
                            ((unit_sel_q == U_LOGIC) && (op_sel_q == OP_NOT));

    assign rf_we = (state_q == S_EXEC) && (unit_sel_q == U_STORE);

    calc_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we    (rf_we),
        .waddr (op_sel_q[IDX_W-1:0]),
        .wdata (opa_q),
        .raddr (op_sel_q[IDX_W-1:0]),
        .rdata (rf_rdata)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_MODE;
            boot_q         <= 1'b1;
            prompt_valid_q <= 1'b0;
            prompt_id_q    <= '0;
            prompt_arg_q   <= '0;
            unit_sel_q     <= '0;
            op_sel_q       <= '0;
            opa_q          <= '0;
            opb_q          <= '0;
            out_q          <= '0;
            err_q          <= 1'b0;
            k_q            <= '0;
            tmo_q          <= '0;
        end else begin
            state_q        <= state_d;
            boot_q         <= boot_d;
            prompt_valid_q <= prompt_valid_d;
            prompt_id_q    <= prompt_id_d;
            prompt_arg_q   <= prompt_arg_d;
            unit_sel_q     <= unit_sel_d;
            op_sel_q       <= op_sel_d;
            opa_q          <= opa_d;
            opb_q          <= opb_d;
            out_q          <= out_d;
            err_q          <= err_d;
            k_q            <= k_d;
            tmo_q          <= tmo_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d        = state_q;
        boot_d         = 1'b0;
        prompt_valid_d = prompt_valid_q;
        prompt_id_d    = prompt_id_q;
        prompt_arg_d   = prompt_arg_q;
        unit_sel_d     = unit_sel_q;
        op_sel_d       = op_sel_q;
        opa_d          = opa_q;
        opb_d          = opb_q;
        out_d          = out_q;
        err_d          = err_q;
        k_d            = k_q;
        tmo_d          = tmo_q;

        if (prompt_valid_q && prompt_ready) begin
            prompt_valid_d = 1'b0;
        end

        if (boot_q) begin
            prompt_valid_d = 1'b1;
            prompt_id_d    = P_MODE;
            prompt_arg_d   = 8'd0;
        end

        case (state_q)
            S_MODE: begin
                if (press) begin
                    prompt_valid_d = 1'b1;
                    prompt_arg_d   = 8'd0;
                    if (switches[2:0] > U_STORE) begin
                        err_d       = 1'b1;
                        prompt_id_d = P_ERROR;
                    end else begin
                        err_d       = 1'b0;
                        unit_sel_d  = switches[2:0];
                        prompt_id_d = {2'b00, switches[2:0]} + 5'd1;
                        state_d     = S_OP;
                    end
                end
            end
            S_OP: begin
                if (press) begin
                    op_sel_d = switches[2:0];
                    if (unit_sel_q == U_FETCH) begin
                        state_d = S_EXEC;
                    end else begin
                        opa_d          = '0;
                        opb_d          = '0;
                        k_d            = 8'd0;
                        prompt_valid_d = 1'b1;
                        prompt_id_d    = P_ENTER_A;
                        prompt_arg_d   = 8'd0;
                        state_d        = S_A;
                    end
                end
            end
            S_A, S_B: begin
                if (press) begin
                    if (state_q == S_A) begin
                        opa_d[int'(k_q)*SW_W +: SW_W] = switches;
                    end else begin
                        opb_d[int'(k_q)*SW_W +: SW_W] = switches;
                    end
                    if (k_q == 8'(WORDS - 1)) begin
                        k_d = 8'd0;
                        if (state_q == S_A && !single_operand) begin
                            prompt_valid_d = 1'b1;
                            prompt_id_d    = P_ENTER_B;
                            prompt_arg_d   = 8'd0;
                            state_d        = S_B;
                        end else begin
                            state_d = S_EXEC;
                        end
                    end else begin
                        k_d            = k_q + 8'd1;
                        prompt_valid_d = 1'b1;
                        prompt_arg_d   = k_q + 8'd1;
                    end
                end
            end
            S_EXEC: begin
                // Count starts at 1 in the first WAIT cycle, so tmo_q equals
                // the number of cycles elapsed since the start cycle.
                tmo_d = TMO_W'(1);
                if (unit_sel_q == U_STORE || unit_sel_q == U_FETCH) begin
                    out_d          = (unit_sel_q == U_STORE) ? opa_q : rf_rdata;
                    prompt_valid_d = 1'b1;
                    prompt_id_d    = P_OUTPUT;
                    prompt_arg_d   = 8'd0;
                    state_d        = S_SHOW;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result arriving in the timeout cycle takes priority.
                if (result_valid) begin
                    out_d          = result;
                    prompt_valid_d = 1'b1;
                    prompt_id_d    = P_OUTPUT;
                    prompt_arg_d   = 8'd0;
                    state_d        = S_SHOW;
                end else if (tmo_q == TMO_W'(TIMEOUT)) begin
                    err_d          = 1'b1;
                    prompt_valid_d = 1'b1;
                    prompt_id_d    = P_ERROR;
                    prompt_arg_d   = 8'd0;
                    state_d        = S_SHOW;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_SHOW: begin
                if (press) begin
                    prompt_valid_d = 1'b1;
                    prompt_id_d    = P_MODE;
                    prompt_arg_d   = 8'd0;
                    state_d        = S_MODE;
                end
            end
            default: begin
                state_d = S_MODE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        start = 1'b0;
        busy  = 1'b0;
        case (state_q)
            S_EXEC: begin
                busy  = 1'b1;
                start = (unit_sel_q != U_STORE) && (unit_sel_q != U_FETCH);
            end
            S_WAIT: begin
                busy = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign prompt_valid = prompt_valid_q;
    assign prompt_id    = prompt_id_q;
    assign prompt_arg   = prompt_arg_q;
    assign unit_sel     = unit_sel_q;
    assign op_sel       = op_sel_q;
    assign opa          = opa_q;
    assign opb          = opb_q;
    assign out          = out_q;
    assign err          = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int DATA_W  = 32;
    localparam int SW_W    = 16;
    localparam int NREGS   = 4;
    localparam int TIMEOUT = 1023;
    localparam int WORDS   = DATA_W / SW_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              btn_pulse;
    logic [SW_W-1:0]   switches;
    logic              prompt_valid;
    logic [4:0]        prompt_id;
    logic [7:0]        prompt_arg;
    logic              prompt_ready;
    logic [2:0]        unit_sel;
    logic [2:0]        op_sel;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic              start;
    logic              result_valid;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] out;
    logic              busy;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;
    int starts_seen = 0;

    // Expected prompts {id, arg}, pushed as presses are driven
    logic [12:0] exp_q[$];

    typedef struct {
        logic [2:0]  unit;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;       // value the stand-in execution unit returns
        int          lat;       // cycles after start; 0 = never answers
        logic [31:0] exp_out;
        logic        exp_err;
        int          exp_starts;
    } vec_t;

    vec_t vecs[10];

    calc_sequencer #(
        .DATA_W  (DATA_W),
        .SW_W    (SW_W),
        .NREGS   (NREGS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_pulse    (btn_pulse),
        .switches     (switches),
        .prompt_valid (prompt_valid),
        .prompt_id    (prompt_id),
        .prompt_arg   (prompt_arg),
        .prompt_ready (prompt_ready),
        .unit_sel     (unit_sel),
        .op_sel       (op_sel),
        .opa          (opa),
        .opb          (opb),
        .start        (start),
        .result_valid (result_valid),
        .result       (result),
        .out          (out),
        .busy         (busy),
        .err          (err)
    );

    // Clock
    always #5 clk = ~clk;

    // Start-pulse counter, sampled away from the active edge
    always @(negedge clk) begin
        if (start === 1'b1) starts_seen++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait for a pending prompt, compare it with the scoreboard, accept it.
    task automatic take_prompt(input string name);
        int n;
        logic [12:0] e;
        n = 0;
        while (prompt_valid !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (prompt_valid !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no prompt within %0d cycles", name, n);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: unexpected prompt id %0d arg %0d", name, prompt_id, prompt_arg);
        end else begin
            e = exp_q.pop_front();
            check(name, {51'd0, prompt_id, prompt_arg}, {51'd0, e});
        end
        prompt_ready = 1'b1;
        @(negedge clk);
        prompt_ready = 1'b0;
    endtask

    task automatic press(input logic [SW_W-1:0] sw);
        switches  = sw;
        btn_pulse = 1'b1;
        @(negedge clk);
        btn_pulse = 1'b0;
    endtask

    task automatic apply_reset();
        rst          = 1'b1;
        btn_pulse    = 1'b0;
        prompt_ready = 1'b0;
        result_valid = 1'b0;
        result       = '0;
        switches     = '0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back({P_MODE, 8'd0});
    endtask

    // One full operation from MODE (no prompt pending) back to MODE.
    // With abort set, reset is asserted in the first WAIT cycle instead.
    task automatic run_vec(input vec_t v, input bit abort);
        int          s0;
        int          n;
        logic        skip_b;
        logic [4:0]  menu_id;
        logic [31:0] exp_opb;
        s0      = starts_seen;
        skip_b  = (v.unit == U_STORE) || (v.unit == U_LOGIC && v.op == OP_NOT);
        menu_id = {2'b00, v.unit} + 5'd1;
        exp_opb = skip_b ? 32'd0 : v.b;

        exp_q.push_back({menu_id, 8'd0});
        press({13'd0, v.unit});
        take_prompt("unit_menu");
        if (v.unit != U_FETCH) exp_q.push_back({P_ENTER_A, 8'd0});
        press({13'd0, v.op});
        if (v.unit != U_FETCH) begin
            for (int k = 0; k < WORDS; k++) begin
                take_prompt("enter_a");
                if (k < WORDS - 1) exp_q.push_back({P_ENTER_A, 8'(k + 1)});
                else if (!skip_b) exp_q.push_back({P_ENTER_B, 8'd0});
                press(v.a[k*SW_W +: SW_W]);
            end
            if (!skip_b) begin
                for (int k = 0; k < WORDS; k++) begin
                    take_prompt("enter_b");
                    if (k < WORDS - 1) exp_q.push_back({P_ENTER_B, 8'(k + 1)});
                    press(v.b[k*SW_W +: SW_W]);
                end
            end
        end

        if (v.unit != U_FETCH && v.unit != U_STORE) begin
            n = 0;
            while (start !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("start_seen", {63'd0, start}, 64'd1);
            check("busy_exec", {63'd0, busy}, 64'd1);
            check("opa", {32'd0, opa}, {32'd0, v.a});
            check("opb", {32'd0, opb}, {32'd0, exp_opb});
            if (abort) begin
                @(negedge clk);
                rst = 1'b1;
                #1;
                check("rst_start", {63'd0, start}, 64'd0);
                check("rst_busy", {63'd0, busy}, 64'd0);
                check("rst_opa", {32'd0, opa}, 64'd0);
                check("rst_opb", {32'd0, opb}, 64'd0);
                check("rst_out", {32'd0, out}, 64'd0);
                check("rst_sel", {58'd0, unit_sel, op_sel}, 64'd0);
                check("rst_prompt", {50'd0, prompt_valid, prompt_id, prompt_arg}, 64'd0);
                check("rst_state", {61'd0, dut.state_q}, {61'd0, S_MODE});
                return;
            end
            if (v.lat > 0) begin
                repeat (v.lat) @(negedge clk);
                result_valid = 1'b1;
                result       = v.res;
                @(negedge clk);
                result_valid = 1'b0;
                result       = '0;
            end
        end

        exp_q.push_back({v.exp_err ? P_ERROR : P_OUTPUT, 8'd0});
        take_prompt("show_prompt");
        check("out", {32'd0, out}, {32'd0, v.exp_out});
        check("err", {63'd0, err}, {63'd0, v.exp_err});
        check("start_count", 64'(starts_seen - s0), 64'(v.exp_starts));
        check("busy_show", {63'd0, busy}, 64'd0);
        exp_q.push_back({P_MODE, 8'd0});
        press('0);
        take_prompt("mode_prompt");
        check("err_sticky", {63'd0, err}, {63'd0, v.exp_err});
    endtask

    initial begin
        // Vector table: unit, op, a, b, eu result, latency, out, err, starts
        vecs[0] = '{3'd1, 3'd0, 32'h1234_5678, 32'h0000_0001, 32'h1234_5679, 1,
                    32'h1234_5679, 1'b0, 1};
        vecs[1] = '{3'd5, 3'd2, 32'hDEAD_BEEF, 32'h0, 32'h0, 0,
                    32'hDEAD_BEEF, 1'b0, 0};
        vecs[2] = '{3'd4, 3'd2, 32'h0, 32'h0, 32'h0, 0,
                    32'hDEAD_BEEF, 1'b0, 0};
        vecs[3] = '{3'd3, 3'd6, 32'h0F0F_0F0F, 32'h0, 32'hF0F0_F0F0, 3,
                    32'hF0F0_F0F0, 1'b0, 1};
        vecs[4] = '{3'd0, 3'd3, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, TIMEOUT,
                    32'h4040_0000, 1'b0, 1};
        vecs[5] = '{3'd2, 3'd1, 32'hAAAA_5555, 32'h0000_FFFF, 32'h0, 0,
                    32'h4040_0000, 1'b1, 1};
        vecs[6] = '{3'd3, 3'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 2,
                    32'h0F00_0F00, 1'b0, 1};
        vecs[7] = '{3'd5, 3'd3, 32'hCAFE_F00D, 32'h0, 32'h0, 0,
                    32'hCAFE_F00D, 1'b0, 0};
        vecs[8] = '{3'd4, 3'd3, 32'h0, 32'h0, 32'h0, 0,
                    32'hCAFE_F00D, 1'b0, 0};
        vecs[9] = '{3'd4, 3'd0, 32'h0, 32'h0, 32'h0, 0,
                    32'h0, 1'b0, 0};

        // Reset values
        rst          = 1'b1;
        btn_pulse    = 1'b0;
        prompt_ready = 1'b0;
        result_valid = 1'b0;
        result       = '0;
        switches     = '0;
        repeat (3) @(negedge clk);
        check("reset_prompt", {50'd0, prompt_valid, prompt_id, prompt_arg}, 64'd0);
        check("reset_ops", {opa, opb}, 64'd0);
        check("reset_out", {31'd0, out, err}, 64'd0);
        check("reset_ctl", {56'd0, unit_sel, op_sel, start, busy}, 64'd0);
        rst = 1'b0;
        exp_q.push_back({P_MODE, 8'd0});

        // Press while the MODE prompt is pending is dropped
        repeat (5) @(negedge clk);
        press(16'd1);
        @(negedge clk);
        check("pending_valid", {63'd0, prompt_valid}, 64'd1);
        check("pending_id", {59'd0, prompt_id}, 64'd0);
        check("pending_state", {61'd0, dut.state_q}, {61'd0, S_MODE});
        check("pending_unit", {61'd0, unit_sel}, 64'd0);

        // Press coincident with the handshake cycle is dropped
        check("hs_id", {59'd0, prompt_id}, 64'd0);
        void'(exp_q.pop_front());
        prompt_ready = 1'b1;
        switches     = 16'd1;
        btn_pulse    = 1'b1;
        @(negedge clk);
        prompt_ready = 1'b0;
        btn_pulse    = 1'b0;
        @(negedge clk);
        check("hs_valid", {63'd0, prompt_valid}, 64'd0);
        check("hs_state", {61'd0, dut.state_q}, {61'd0, S_MODE});
        check("hs_unit", {61'd0, unit_sel}, 64'd0);

        // result_valid outside WAIT is ignored
        result       = 32'hFFFF_FFFF;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        result       = '0;
        @(negedge clk);
        check("idle_result", {32'd0, out}, 64'd0);

        // Invalid unit code
        exp_q.push_back({P_ERROR, 8'd0});
        press(16'd7);
        take_prompt("invalid_prompt");
        check("invalid_err", {63'd0, err}, 64'd1);
        check("invalid_state", {61'd0, dut.state_q}, {61'd0, S_MODE});

        // Table-driven operations
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], 1'b0);
        end

        // Reset while waiting for a result, then the stored register reads 0
        run_vec(vecs[0], 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back({P_MODE, 8'd0});
        take_prompt("post_reset_mode");
        vecs[2].exp_out = 32'h0;
        run_vec(vecs[2], 1'b0);

        check("prompts_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
